// File: rtl/systolic_mm_engine_param.sv
// N x N output-stationary systolic matrix multiplier with a LOAD/COMPUTE/DRAIN controller.
// Optional macro ACCUM_EN: start with accum=1 keeps the previous C and adds A x B to it.
module systolic_mm_engine_param #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 2*DW + $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          accum,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] c_out,
  output logic          busy,
  output logic          done
);

  localparam int NN = N*N;
  localparam int KW = $clog2(NN);
  localparam int TW = $clog2(3*N-2);
  localparam logic [KW-1:0] K_LAST = KW'(NN-1);
  localparam logic [TW-1:0] T_LAST = TW'(3*N-3);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the engine raises in_ready only in LOAD and out_valid only in DRAIN, and holds c_out while stalled.

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN} state_t;
  state_t state;

  logic [KW-1:0] k_cnt;
  logic [KW-1:0] m_cnt;
  logic [TW-1:0] t_cnt;
  logic [DW-1:0] a_buf [NN];
  logic [DW-1:0] b_buf [NN];
  logic [DW-1:0] a_edge [N];
  logic [DW-1:0] b_edge [N];
  logic [DW-1:0] a_fwd [N][N];
  logic [DW-1:0] b_fwd [N][N];
  logic [AW-1:0] c_flat [NN];

  logic keep_acc;
  logic clr_acc;
  logic run;

`ifdef ACCUM_EN
  assign keep_acc = accum;
`else
  logic unused_accum;
  assign unused_accum = accum;
  assign keep_acc = 1'b0;
`endif

  assign clr_acc = (state == S_IDLE) && start && !keep_acc;
  assign run     = (state == S_COMPUTE);

  // Skewed edge feed: row i / column j start i / j cycles late, zeros outside the window.
  int d;
  logic [KW-1:0] idx;
  always_comb begin
    d   = 0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      a_edge[i] = '0;
      b_edge[i] = '0;
    end
    if (run) begin
      for (int i = 0; i < N; i++) begin
        d = int'(t_cnt) - i;
        if (d >= 0 && d < N) begin
          idx       = KW'(i*N + d);
          a_edge[i] = a_buf[idx];
          idx       = KW'(d*N + i);
          b_edge[i] = b_buf[idx];
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0] a_w, b_w, a_q, b_q;
      logic [AW-1:0] acc_q, prod;

      if (j == 0) begin : g_a_edge
        assign a_w = a_edge[i];
      end else begin : g_a_pipe
        assign a_w = a_fwd[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_w = b_edge[j];
      end else begin : g_b_pipe
        assign b_w = b_fwd[i-1][j];
      end

      assign prod = AW'(a_w) * AW'(b_w);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else if (run) begin
          a_q   <= a_w;
          b_q   <= b_w;
          acc_q <= acc_q + prod;
        end else begin
          a_q <= '0;
          b_q <= '0;
          if (clr_acc) acc_q <= '0;
        end
      end

      assign a_fwd[i][j]    = a_q;
      assign b_fwd[i][j]    = b_q;
      assign c_flat[i*N+j]  = acc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      c_out     <= '0;
      k_cnt     <= '0;
      m_cnt     <= '0;
      t_cnt     <= '0;
      for (int n = 0; n < NN; n++) begin
        a_buf[n] <= '0;
        b_buf[n] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            k_cnt    <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            a_buf[k_cnt] <= a_in;
            b_buf[k_cnt] <= b_in;
            if (k_cnt == K_LAST) begin
              state    <= S_COMPUTE;
              in_ready <= 1'b0;
              t_cnt    <= '0;
            end else begin
              k_cnt <= k_cnt + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          // PE(0,0) finished long ago, so C[0][0] is safe to register on the last compute edge.
          if (t_cnt == T_LAST) begin
            state     <= S_DRAIN;
            out_valid <= 1'b1;
            m_cnt     <= '0;
            c_out     <= c_flat[0];
          end else begin
            t_cnt <= t_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (m_cnt == K_LAST) begin
              state     <= S_IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              m_cnt <= m_cnt + 1'b1;
              c_out <= c_flat[m_cnt + 1'b1];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_mm_engine_param.sv
// Directed bench for systolic_mm_engine_param: a 4x4 instance plus a 2x2 instance.
// Honours ACCUM_EN the same way as the design when the macro is defined.
module tb_systolic_mm_engine_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, accum, in_valid, out_ready;
  logic        in_ready, out_valid, busy, done;
  logic [7:0]  a_in, b_in;
  logic [17:0] c_out;

  logic        start2, in_valid2, out_ready2;
  logic        in_ready2, out_valid2, busy2, done2;
  logic [7:0]  a_in2, b_in2;
  logic [16:0] c_out2;

  systolic_mm_engine_param #(.N(4), .DW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .accum(accum),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .c_out(c_out),
    .busy(busy), .done(done)
  );

  systolic_mm_engine_param #(.N(2), .DW(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .accum(1'b0),
    .in_valid(in_valid2), .in_ready(in_ready2), .a_in(a_in2), .b_in(b_in2),
    .out_valid(out_valid2), .out_ready(out_ready2), .c_out(c_out2),
    .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  va [16];
  logic [7:0]  vb [16];
  logic [17:0] got_q [$];
  logic [17:0] exp_q [$];
  logic [16:0] got2_q [$];
  logic [16:0] exp2_q [$];
  int          job_cycles;
  int          unstable;
  int          timeout;

  // ---------------- driver tasks ----------------
  task automatic run_job(input logic acc_in, input bit bubbles, input bit stalls, input bit poke);
    int k, g, cyc;
    bit hs, held_v, seen_done;
    logic [17:0] held;
    got_q.delete();
    unstable = 0; timeout = 0; seen_done = 0; held = '0;
    start = 1'b1; accum = acc_in; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; accum = 1'b0; cyc = 1;
    k = 0; g = 0;
    while (k < 16 && g < 400) begin
      in_valid = bubbles ? (g % 2 == 0) : 1'b1;
      start    = poke && (g % 3 == 0);
      a_in = va[k]; b_in = vb[k];
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++; g++;
      if (hs) k++;
    end
    in_valid = 1'b0;
    if (k < 16) timeout = 1;
    held_v = 0; g = 0;
    while (g < 400) begin
      out_ready = stalls ? (g % 4 == 3) : 1'b1;
      start     = poke && (g % 3 == 1);
      if (held_v && (!out_valid || c_out !== held)) unstable++;
      if (out_valid && out_ready) got_q.push_back(c_out);
      held_v = out_valid && !out_ready;
      held   = c_out;
      @(posedge clk); #1;
      cyc++; g++;
      if (done) begin seen_done = 1; break; end
    end
    if (!seen_done) timeout = 1;
    job_cycles = cyc;
    start = 1'b0; out_ready = 1'b0;
  endtask

  task automatic run_job2(input logic [7:0] a[4], input logic [7:0] b[4]);
    int k, g;
    bit hs, seen_done;
    got2_q.delete();
    timeout = 0; seen_done = 0;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    k = 0; g = 0;
    while (k < 4 && g < 100) begin
      in_valid2 = 1'b1; a_in2 = a[k]; b_in2 = b[k];
      hs = in_ready2;
      @(posedge clk); #1;
      g++;
      if (hs) k++;
    end
    in_valid2 = 1'b0;
    g = 0;
    while (g < 100) begin
      out_ready2 = 1'b1;
      if (out_valid2) got2_q.push_back(c_out2);
      @(posedge clk); #1;
      g++;
      if (done2) begin seen_done = 1; break; end
    end
    if (!seen_done || k < 4) timeout = 1;
    out_ready2 = 1'b0;
  endtask

  task automatic load_basic();
    for (int k = 0; k < 16; k++) begin
      va[k] = 8'(k % 4 + 1);
      vb[k] = 8'(k / 4 + 1);
    end
  endtask

  task automatic load_border();
    for (int k = 0; k < 16; k++) begin
      va[k] = (k / 4 == 0 || k / 4 == 3 || k % 4 == 0 || k % 4 == 3) ? 8'd1 : 8'd0;
      vb[k] = 8'(2 * k + 12);
    end
    exp_q = '{96, 104, 112, 120, 48, 52, 56, 60, 48, 52, 56, 60, 96, 104, 112, 120};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_vec++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_vec++; if (c_out !== 18'd0)    begin n_err++; $display("FAIL reset_c_out got=%0d exp=0", c_out); end
  endtask

  task automatic test_basic();
    load_basic();
    run_job(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (timeout !== 0) begin n_err++; $display("FAIL basic_timeout got=%0d exp=0", timeout); end
    n_vec++; if (job_cycles !== 43) begin n_err++; $display("FAIL basic_latency got=%0d exp=43", job_cycles); end
    n_vec++; if (got_q.size() !== 16) begin n_err++; $display("FAIL basic_count got=%0d exp=16", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== 18'd30) begin n_err++; $display("FAIL basic_c[%0d] got=%0d exp=30", i, got_q[i]); end
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_border();
    load_border();
    run_job(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (got_q.size() !== 16) begin n_err++; $display("FAIL border_count got=%0d exp=16", got_q.size()); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL border_c[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back_stalls();
    load_border();
    run_job(1'b0, 1'b1, 1'b1, 1'b0);
    n_vec++; if (timeout !== 0) begin n_err++; $display("FAIL stall_timeout got=%0d exp=0", timeout); end
    n_vec++; if (unstable !== 0) begin n_err++; $display("FAIL stall_hold got=%0d exp=0", unstable); end
    n_vec++; if (got_q.size() !== 16) begin n_err++; $display("FAIL stall_count got=%0d exp=16", got_q.size()); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL stall_c[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_extremes();
    logic [7:0] a2 [4];
    logic [7:0] b2 [4];
    for (int k = 0; k < 16; k++) begin va[k] = 8'd255; vb[k] = 8'd255; end
    run_job(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (got_q.size() !== 16) begin n_err++; $display("FAIL max_count got=%0d exp=16", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== 18'd260100) begin n_err++; $display("FAIL max_c[%0d] got=%0d exp=260100", i, got_q[i]); end
    end
    a2 = '{8'd1, 8'd2, 8'd3, 8'd4};
    b2 = '{8'd5, 8'd6, 8'd7, 8'd8};
    exp2_q = '{19, 22, 43, 50};
    run_job2(a2, b2);
    n_vec++; if (timeout !== 0) begin n_err++; $display("FAIL n2_timeout got=%0d exp=0", timeout); end
    n_vec++; if (got2_q.size() !== 4) begin n_err++; $display("FAIL n2_count got=%0d exp=4", got2_q.size()); end
    for (int i = 0; i < 4 && i < got2_q.size(); i++) begin
      n_vec++;
      if (got2_q[i] !== exp2_q[i]) begin n_err++; $display("FAIL n2_c[%0d] got=%0d exp=%0d", i, got2_q[i], exp2_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      a_in = 8'($urandom_range(0, 255));
      b_in = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_in_ready got=%b exp=0", in_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    n_vec++; if (c_out !== 18'd0) begin n_err++; $display("FAIL mid_c_out got=%0d exp=0", c_out); end
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    load_basic();
    run_job(1'b0, 1'b0, 1'b0, 1'b1);
    n_vec++; if (job_cycles !== 43) begin n_err++; $display("FAIL mid_latency got=%0d exp=43", job_cycles); end
    n_vec++; if (got_q.size() !== 16) begin n_err++; $display("FAIL mid_count got=%0d exp=16", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== 18'd30) begin n_err++; $display("FAIL mid_c[%0d] got=%0d exp=30", i, got_q[i]); end
    end
  endtask

  task automatic test_accum();
    logic [17:0] exp_second;
`ifdef ACCUM_EN
    exp_second = 18'd60;
`else
    exp_second = 18'd30;
`endif
    load_basic();
    run_job(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== 18'd30) begin n_err++; $display("FAIL acc_first_c[%0d] got=%0d exp=30", i, got_q[i]); end
    end
    run_job(1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++; if (got_q.size() !== 16) begin n_err++; $display("FAIL acc_count got=%0d exp=16", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_second) begin n_err++; $display("FAIL acc_second_c[%0d] got=%0d exp=%0d", i, got_q[i], exp_second); end
    end
  endtask

  // ---------------- clock/reset and sequence ----------------
  initial begin
    rst = 1'b1;
    start = 1'b0; accum = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0;
    start2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0;
    a_in2 = '0; b_in2 = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_border();
    test_back_to_back_stalls();
    test_extremes();
    test_reset_mid();
    test_accum();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
